// File: rtl/dual_adc_capture.sv
// Dual 8-bit ADC capture: divided conversion clock, button-armed rising-edge trigger
// on channel A, one buffer of {B,A} pairs in a single-port RAM streamed out over valid/ready.
module dual_adc_capture #(
  parameter int         CLK_DIV    = 4,
  parameter int         DEPTH_LOG2 = 8,
  parameter logic [7:0] TRIG_LEVEL = 8'h80
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        button,
  input  logic [7:0]  adc_a_d,
  input  logic [7:0]  adc_b_d,
  output logic        adc_a_c,
  output logic        adc_b_c,
  output logic [2:0]  led,
  output logic [15:0] out_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        out_last
);

  localparam int                    DIV_W     = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0]      DIV_LAST  = DIV_W'(CLK_DIV - 1);
  localparam logic [DIV_W-1:0]      DIV_HALF  = DIV_W'(CLK_DIV / 2);
  localparam logic [DEPTH_LOG2-1:0] ADDR_LAST = {DEPTH_LOG2{1'b1}};
  localparam int                    DEPTH     = 1 << DEPTH_LOG2;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ARMED   = 2'd1,
    ST_CAPTURE = 2'd2,
    ST_DONE    = 2'd3
  } state_t;

  state_t                state_r, state_nx_s;
  logic [DIV_W-1:0]      div_cnt_r, div_nx_s;
  logic                  adc_c_r, strobe_s;
  logic                  btn_s1_r, btn_s2_r, btn_s3_r, press_s;
  logic [7:0]            prev_a_r;
  logic                  have_prev_r;
  logic                  trig_s, wr_en_s, last_wr_s;
  logic [DEPTH_LOG2-1:0] wr_addr_r, rd_addr_r, ram_addr_s;
  logic [15:0]           mem [DEPTH];
  logic [15:0]           rq_data_r;
  logic                  rq_valid_r, rq_last_r, rd_done_r;
  logic                  in_done_s, transfer_s, out_load_s, rd_issue_s;
  logic [2:0]            led_nx_s, led_r;
  logic [15:0]           out_data_r;
  logic                  out_valid_r, out_last_r;

  // next divider count, wrapping at CLK_DIV-1
  always_comb begin
    div_nx_s = div_cnt_r;
    if (div_cnt_r == DIV_LAST) begin
      div_nx_s = {DIV_W{1'b0}};
    end else begin
      div_nx_s = div_cnt_r + DIV_W'(1);
    end
  end

  // conversion clock is registered from the next count so it lines up with div_cnt
  always_ff @(posedge clk) begin
    if (rst) begin
      div_cnt_r <= {DIV_W{1'b0}};
      adc_c_r   <= 1'b0;
    end else begin
      div_cnt_r <= div_nx_s;
      adc_c_r   <= (div_nx_s >= DIV_HALF);
    end
  end

  assign strobe_s = (div_cnt_r == DIV_LAST);
  assign adc_a_c  = adc_c_r;
  assign adc_b_c  = adc_c_r;

  // button synchroniser plus one delay flop for edge detection; idles released
  always_ff @(posedge clk) begin
    if (rst) begin
      btn_s1_r <= 1'b1;
      btn_s2_r <= 1'b1;
      btn_s3_r <= 1'b1;
    end else begin
      btn_s1_r <= button;
      btn_s2_r <= btn_s1_r;
      btn_s3_r <= btn_s2_r;
    end
  end

  assign press_s = btn_s3_r & ~btn_s2_r;

  // previous channel A sample; the first strobe after arming only primes it
  always_ff @(posedge clk) begin
    if (rst) begin
      prev_a_r    <= 8'h00;
      have_prev_r <= 1'b0;
    end else if ((state_r == ST_ARMED) && strobe_s) begin
      prev_a_r    <= adc_a_d;
      have_prev_r <= 1'b1;
    end else if (state_r != ST_ARMED) begin
      have_prev_r <= 1'b0;
    end
  end

  assign trig_s    = (state_r == ST_ARMED) && strobe_s && have_prev_r &&
                     (prev_a_r < TRIG_LEVEL) && (adc_a_d >= TRIG_LEVEL);
  assign wr_en_s   = trig_s || ((state_r == ST_CAPTURE) && strobe_s);
  assign last_wr_s = (state_r == ST_CAPTURE) && strobe_s && (wr_addr_r == ADDR_LAST);

  // write address: trigger pair lands at 0, then one word per strobe
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_addr_r <= {DEPTH_LOG2{1'b0}};
    end else if (wr_en_s) begin
      wr_addr_r <= wr_addr_r + DEPTH_LOG2'(1);
    end else if (state_r != ST_CAPTURE) begin
      wr_addr_r <= {DEPTH_LOG2{1'b0}};
    end
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nx_s;
    end
  end

  assign in_done_s  = (state_r == ST_DONE);
  assign transfer_s = out_valid_r & out_ready;

  // FSM next-state logic; presses only matter in IDLE
  always_comb begin
    state_nx_s = state_r;
    case (state_r)
      ST_IDLE:    if (press_s) state_nx_s = ST_ARMED; else state_nx_s = ST_IDLE;
      ST_ARMED:   if (trig_s) state_nx_s = ST_CAPTURE; else state_nx_s = ST_ARMED;
      ST_CAPTURE: if (last_wr_s) state_nx_s = ST_DONE; else state_nx_s = ST_CAPTURE;
      ST_DONE:    if (transfer_s && out_last_r) state_nx_s = ST_IDLE; else state_nx_s = ST_DONE;
      default:    state_nx_s = ST_IDLE;
    endcase
  end

  // FSM output decode, taken from the next state so the registered LEDs track state_r
  always_comb begin
    led_nx_s = 3'b000;
    case (state_nx_s)
      ST_IDLE:    led_nx_s = 3'b000;
      ST_ARMED:   led_nx_s = 3'b001;
      ST_CAPTURE: led_nx_s = 3'b010;
      ST_DONE:    led_nx_s = 3'b100;
      default:    led_nx_s = 3'b000;
    endcase
  end

  // LED register
  always_ff @(posedge clk) begin
    if (rst) begin
      led_r <= 3'b000;
    end else begin
      led_r <= led_nx_s;
    end
  end

  // Two-stage readout: RAM output register feeds the output register, so a read is
  // issued whenever the RAM stage is empty or moving, sustaining one word per cycle.
  assign out_load_s = in_done_s && (!out_valid_r || out_ready);
  assign rd_issue_s = in_done_s && !rd_done_r && (!rq_valid_r || out_load_s);

  // single address port: capture and readout never overlap in time
  always_comb begin
    ram_addr_s = wr_addr_r;
    if (in_done_s) begin
      ram_addr_s = rd_addr_r;
    end else begin
      ram_addr_s = wr_addr_r;
    end
  end

  // capture RAM, contents are not reset
  always_ff @(posedge clk) begin
    if (wr_en_s) begin
      mem[ram_addr_s] <= {adc_b_d, adc_a_d};
    end
    if (rd_issue_s) begin
      rq_data_r <= mem[ram_addr_s];
    end
  end

  // read address and RAM-stage bookkeeping, cleared outside DONE
  always_ff @(posedge clk) begin
    if (rst || !in_done_s) begin
      rd_addr_r  <= {DEPTH_LOG2{1'b0}};
      rd_done_r  <= 1'b0;
      rq_valid_r <= 1'b0;
      rq_last_r  <= 1'b0;
    end else if (rd_issue_s) begin
      rd_addr_r  <= rd_addr_r + DEPTH_LOG2'(1);
      rd_done_r  <= (rd_addr_r == ADDR_LAST);
      rq_valid_r <= 1'b1;
      rq_last_r  <= (rd_addr_r == ADDR_LAST);
    end else if (out_load_s) begin
      rq_valid_r <= 1'b0;
    end
  end

  // output register holds while stalled
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_r <= 1'b0;
      out_last_r  <= 1'b0;
      out_data_r  <= 16'h0000;
    end else if (!in_done_s) begin
      out_valid_r <= 1'b0;
      out_last_r  <= 1'b0;
    end else if (out_load_s) begin
      out_valid_r <= rq_valid_r;
      out_last_r  <= rq_valid_r & rq_last_r;
      if (rq_valid_r) begin
        out_data_r <= rq_data_r;
      end
    end
  end

  assign led       = led_r;
  assign out_data  = out_data_r;
  assign out_valid = out_valid_r;
  assign out_last  = out_last_r;

endmodule

// File: tb/tb_dual_adc_capture.sv
// Self-checking bench for dual_adc_capture (CLK_DIV=4, DEPTH_LOG2=4): vector table for
// reset/divider/press timing, ramp-driven captures checked against a scoreboard queue.
module tb_dual_adc_capture;

  logic        clk = 1'b0;
  logic        rst, button, out_ready;
  logic [7:0]  adc_a_d, adc_b_d;
  logic        adc_a_c, adc_b_c, out_valid, out_last;
  logic [2:0]  led;
  logic [15:0] out_data;

  int          errors = 0;
  int          checks = 0;
  logic [15:0] exp_q[$];
  logic [7:0]  a_base  = 8'h90;
  logic        ramp_en = 1'b0;

  typedef struct packed {
    logic       rst;
    logic       btn;
    logic       adc_c;
    logic [2:0] led;
    logic       valid;
  } vec_t;

  always #5 clk = ~clk;

  dual_adc_capture #(.CLK_DIV(4), .DEPTH_LOG2(4), .TRIG_LEVEL(8'h80)) dut (
    .clk(clk), .rst(rst), .button(button),
    .adc_a_d(adc_a_d), .adc_b_d(adc_b_d),
    .adc_a_c(adc_a_c), .adc_b_c(adc_b_c), .led(led),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready), .out_last(out_last)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // ADC model: A steps +1 on each conversion-clock rise while ramping, B = ~A.
  // A trigger model fills the scoreboard with the 16 pairs the capture must hold.
  initial begin : adc_model
    logic [7:0] a_val;
    logic [7:0] m_prev;
    logic       m_cap;
    int         m_cnt;
    logic       c_prev;
    a_val = 8'h90; m_prev = 8'h90; m_cap = 1'b0; m_cnt = 0; c_prev = 1'b0;
    adc_a_d = a_val;
    adc_b_d = ~a_val;
    forever begin
      @(negedge clk);
      if (!ramp_en) begin
        a_val = a_base; m_prev = a_base; m_cap = 1'b0; m_cnt = 0;
      end else if (adc_a_c && !c_prev) begin
        a_val = a_val + 8'd1;
        if (!m_cap && (m_prev < 8'h80) && (a_val >= 8'h80)) m_cap = 1'b1;
        if (m_cap && (m_cnt < 16)) begin
          exp_q.push_back({~a_val, a_val});
          m_cnt++;
        end
        m_prev = a_val;
      end
      c_prev  = adc_a_c;
      adc_a_d = a_val;
      adc_b_d = ~a_val;
    end
  end

  task automatic press();
    button = 1'b0;
    repeat (3) @(negedge clk);
    button = 1'b1;
  endtask

  task automatic wait_led(input logic [2:0] exp, input int limit, input string name);
    int n = 0;
    while ((led !== exp) && (n < limit)) begin
      @(negedge clk);
      n++;
    end
    check(name, 32'(led), 32'(exp));
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    rst = 1'b1;
    out_ready = 1'b0;
    ramp_en = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    exp_q.delete();
    check("rst_led", 32'(led), 32'(3'b000));
    check("rst_valid", 32'(out_valid), 32'(1'b0));
    check("rst_last", 32'(out_last), 32'(1'b0));
    check("rst_data", 32'(out_data), 32'(16'h0000));
    check("rst_adc_a_c", 32'(adc_a_c), 32'(1'b0));
    check("rst_adc_b_c", 32'(adc_b_c), 32'(1'b0));
  endtask

  task automatic capture(input bit press_mid);
    logic [15:0] held;
    ramp_en = 1'b0;
    a_base  = 8'h70;
    repeat (4) @(negedge clk);
    press();
    wait_led(3'b001, 20, "arm_led");
    ramp_en = 1'b1;
    wait_led(3'b010, 200, "capture_led");
    check("capture_valid_low", 32'(out_valid), 32'(1'b0));
    if (press_mid) begin
      press();
      repeat (3) @(negedge clk);
      check("capture_press_ignored", 32'(led), 32'(3'b010));
    end
    wait_led(3'b100, 200, "done_led");
    repeat (2) @(negedge clk);
    check("done_valid_within_2", 32'(out_valid), 32'(1'b1));
    check("expected_words", 32'(exp_q.size()), 32'(16));
    if (press_mid) begin
      held = out_data;
      press();
      repeat (4) @(negedge clk);
      check("done_press_ignored", 32'(led), 32'(3'b100));
      check("stall_valid", 32'(out_valid), 32'(1'b1));
      check("stall_data", 32'(out_data), 32'(held));
    end
  endtask

  task automatic readout(input bit rand_ready, input int stop_after);
    int          got = 0;
    int          cyc = 0;
    int          first_c = 0;
    int          last_c = 0;
    bit          stalled = 1'b0;
    logic [15:0] held = 16'h0000;
    logic        held_last = 1'b0;
    logic [15:0] e;
    while ((got < 16) && (cyc < 1000) && !((stop_after != 0) && (got >= stop_after))) begin
      @(negedge clk);
      cyc++;
      if (stalled) begin
        check("hold_valid", 32'(out_valid), 32'(1'b1));
        check("hold_data", 32'(out_data), 32'(held));
        check("hold_last", 32'(out_last), 32'(held_last));
      end
      stalled = 1'b0;
      out_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      if (out_valid) begin
        if (out_ready) begin
          check("queue_nonempty", 32'(exp_q.size() > 0), 32'(1'b1));
          e = (exp_q.size() > 0) ? exp_q.pop_front() : 16'h0000;
          check($sformatf("word%0d", got), 32'(out_data), 32'(e));
          check($sformatf("last%0d", got), 32'(out_last), 32'(got == 15));
          if (got == 0) first_c = cyc;
          last_c = cyc;
          got++;
        end else begin
          stalled   = 1'b1;
          held      = out_data;
          held_last = out_last;
        end
      end
    end
    if (stop_after == 0) begin
      check("readout_count", 32'(got), 32'(16));
      if (!rand_ready) check("throughput", 32'(last_c - first_c), 32'(15));
      @(negedge clk);
      check("valid_after_last", 32'(out_valid), 32'(1'b0));
      check("idle_after_last", 32'(led), 32'(3'b000));
      out_ready = 1'b0;
    end
  endtask

  initial begin : main
    vec_t vecs[10];
    vecs[0] = '{rst: 1'b1, btn: 1'b1, adc_c: 1'b0, led: 3'b000, valid: 1'b0};
    vecs[1] = '{rst: 1'b1, btn: 1'b1, adc_c: 1'b0, led: 3'b000, valid: 1'b0};
    vecs[2] = '{rst: 1'b0, btn: 1'b1, adc_c: 1'b0, led: 3'b000, valid: 1'b0};
    vecs[3] = '{rst: 1'b0, btn: 1'b1, adc_c: 1'b1, led: 3'b000, valid: 1'b0};
    vecs[4] = '{rst: 1'b0, btn: 1'b0, adc_c: 1'b1, led: 3'b000, valid: 1'b0};
    vecs[5] = '{rst: 1'b0, btn: 1'b0, adc_c: 1'b0, led: 3'b000, valid: 1'b0};
    vecs[6] = '{rst: 1'b0, btn: 1'b0, adc_c: 1'b0, led: 3'b001, valid: 1'b0};
    vecs[7] = '{rst: 1'b0, btn: 1'b1, adc_c: 1'b1, led: 3'b001, valid: 1'b0};
    vecs[8] = '{rst: 1'b0, btn: 1'b1, adc_c: 1'b1, led: 3'b001, valid: 1'b0};
    vecs[9] = '{rst: 1'b0, btn: 1'b1, adc_c: 1'b0, led: 3'b001, valid: 1'b0};

    rst = 1'b1; button = 1'b1; out_ready = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 10; i++) begin
      rst    = vecs[i].rst;
      button = vecs[i].btn;
      @(negedge clk);
      check($sformatf("vec%0d_adc_a_c", i), 32'(adc_a_c), 32'(vecs[i].adc_c));
      check($sformatf("vec%0d_adc_b_c", i), 32'(adc_b_c), 32'(vecs[i].adc_c));
      check($sformatf("vec%0d_led", i), 32'(led), 32'(vecs[i].led));
      check($sformatf("vec%0d_valid", i), 32'(out_valid), 32'(vecs[i].valid));
      if (i == 1) begin
        check("reset_data", 32'(out_data), 32'(16'h0000));
        check("reset_last", 32'(out_last), 32'(1'b0));
      end
    end

    // armed with A held at 0x90: no rising crossing ever occurs
    for (int i = 0; i < 6; i++) begin
      repeat (50) @(negedge clk);
      check("held_a_no_trigger", 32'(led), 32'(3'b001));
      check("held_a_valid_low", 32'(out_valid), 32'(1'b0));
    end

    pulse_reset();
    capture(1'b1);
    readout(1'b0, 0);

    // abort mid-readout, then a fresh capture must read out completely
    pulse_reset();
    capture(1'b0);
    readout(1'b0, 5);
    pulse_reset();
    repeat (30) @(negedge clk);
    check("post_abort_led", 32'(led), 32'(3'b000));
    check("post_abort_valid", 32'(out_valid), 32'(1'b0));
    capture(1'b0);
    readout(1'b1, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: sim time %0t exceeded limit 400000", $time);
    $fatal(1, "bench timed out");
  end

endmodule
